// File: rtl/pid_block_packer.sv
// -----------------------------------------------------------------------------
// pid_block_packer
//
// Packs 16-bit PID control samples into 128-bit plaintext blocks for the AES
// stage. Sample 0 of a block lands in the most significant slot
// (m_data[127:112]) and sample 7 lands in the least significant slot
// (m_data[15:0]).
//
// An assembly register and an output register form a double buffer, so
// sample intake continues while the AES side holds off. If a second block
// completes while the output register is still occupied, the packer enters
// STALL. It then refuses input until the AES stage takes the pending block.
//
// A flush closes a partial block and zero-pads the unused slots. A flush on
// an empty block is ignored, so an empty block is never emitted.
//
// Ports
//   clk      : single clock, rising edge
//   rst      : asynchronous, active-high reset
//   s_valid  : a sample is present on s_data
//   s_ready  : the packer accepts a sample or a flush this cycle (registered)
//   s_data   : control sample
//   s_flush  : close the current partial block
//   m_valid  : a block is available on m_data
//   m_ready  : the AES stage consumes the block
//   m_data   : packed plaintext block
//   m_fill   : number of real samples in m_data (1..SAMPLES)
//   blk_cnt  : number of delivered blocks; wraps to 0
// -----------------------------------------------------------------------------
module pid_block_packer #(
    parameter int SAMPLE_W = 16,
    parameter int SAMPLES  = 8,
    parameter int CNT_W    = 16,
    localparam int BLOCK_W = SAMPLE_W * SAMPLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                s_flush,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [BLOCK_W-1:0]  m_data,
    output logic [3:0]          m_fill,
    output logic [CNT_W-1:0]    blk_cnt
);

    localparam int IDX_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

    typedef enum logic {
        ST_FILL,
        ST_STALL
    } state_t;

    state_t               state_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [BLOCK_W-1:0]   asm_reg;
    logic [3:0]           asm_fill_reg;
    logic                 ready_reg;
    logic                 m_valid_reg;
    logic [BLOCK_W-1:0]   m_data_reg;
    logic [3:0]           m_fill_reg;
    logic [CNT_W-1:0]     blk_cnt_reg;

    logic                 sample_acc;
    logic                 flush_acc;
    logic                 last_slot;
    logic                 blk_done;
    logic                 out_hs;
    logic                 out_free;
    logic [BLOCK_W-1:0]   asm_base;
    logic [BLOCK_W-1:0]   blk_next;
    logic [3:0]           fill_next;

    // ready_reg is 1 exactly when the state is FILL, and it is also 0 during
    // reset. Gating the accepts with it keeps STALL input ignored.
    always_comb begin
        sample_acc = s_valid && ready_reg;
        flush_acc  = s_flush && ready_reg;
        last_slot  = (idx_reg == IDX_W'(SAMPLES - 1));
        // A flush completes the block only if the block holds at least one
        // sample. A sample accepted in the same cycle counts.
        blk_done   = (sample_acc && last_slot) ||
                     (flush_acc && ((idx_reg != '0) || sample_acc));
        out_hs     = m_valid_reg && m_ready;
        out_free   = !m_valid_reg || m_ready;
        // Slot 0 starts from all zeros, so the previous block's data cannot
        // show up in the padding of a flushed block.
        asm_base   = (idx_reg == '0) ? '0 : asm_reg;
        fill_next  = 4'(idx_reg) + 4'(sample_acc);
    end

    // Write the incoming sample into its slot. Every other slot keeps the
    // assembled (or cleared) contents.
    generate
        for (genvar gi = 0; gi < SAMPLES; gi++) begin : g_slot
            localparam int HI = BLOCK_W - 1 - gi * SAMPLE_W;
            assign blk_next[HI -: SAMPLE_W] =
                (sample_acc && (idx_reg == IDX_W'(gi))) ? s_data
                                                        : asm_base[HI -: SAMPLE_W];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_FILL;
            idx_reg      <= '0;
            asm_reg      <= '0;
            asm_fill_reg <= '0;
            ready_reg    <= 1'b0;
            m_valid_reg  <= 1'b0;
            m_data_reg   <= '0;
            m_fill_reg   <= '0;
            blk_cnt_reg  <= '0;
        end else begin
            if (out_hs) begin
                blk_cnt_reg <= blk_cnt_reg + CNT_W'(1);
            end

            case (state_reg)
                ST_FILL: begin
                    ready_reg <= 1'b1;
                    if (blk_done) begin
                        idx_reg <= '0;
                        if (out_free) begin
                            // Direct handoff. If the old block leaves on this
                            // same edge, m_valid stays high with no bubble.
                            m_data_reg  <= blk_next;
                            m_fill_reg  <= fill_next;
                            m_valid_reg <= 1'b1;
                        end else begin
                            // The output register is busy. Park the finished
                            // block and stop intake.
                            asm_reg      <= blk_next;
                            asm_fill_reg <= fill_next;
                            state_reg    <= ST_STALL;
                            ready_reg    <= 1'b0;
                        end
                    end else begin
                        if (sample_acc) begin
                            asm_reg <= blk_next;
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                        if (out_hs) begin
                            m_valid_reg <= 1'b0;
                        end
                    end
                end

                ST_STALL: begin
                    // m_valid is always 1 here. The parked block takes the
                    // place of the block that is consumed.
                    if (out_hs) begin
                        m_data_reg <= asm_reg;
                        m_fill_reg <= asm_fill_reg;
                        state_reg  <= ST_FILL;
                        ready_reg  <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_FILL;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready = ready_reg;
    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;
    assign m_fill  = m_fill_reg;
    assign blk_cnt = blk_cnt_reg;

endmodule

// File: doc/pid_block_packer.md
# pid_block_packer

Sequential packer between the PID controller and the AES encryption stage. It accepts one 16-bit PID control sample per handshake and assembles eight samples into a 128-bit plaintext block. It presents each completed block to the AES stage over a valid/ready handshake. A double buffer (assembly register plus output register) lets sample intake continue while the AES side stalls. A flush input zero-pads a partial block.

## Interface
- SAMPLE_W, 16, width of one control sample
- SAMPLES, 8, samples per block; block width BLOCK_W = SAMPLE_W*SAMPLES = 128
- CNT_W, 16, width of the completed-block counter
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  sample present on s_data
- s_ready  out  1  packer can accept a sample or flush this cycle
- s_data  in  SAMPLE_W  control sample
- s_flush  in  1  close current partial block, zero-padding the unused slots
- m_valid  out  1  block available on m_data
- m_ready  in  1  AES stage consumes block
- m_data  out  BLOCK_W  packed plaintext block
- m_fill  out  4  number of real samples in m_data, 1..SAMPLES
- blk_cnt  out  CNT_W  count of blocks delivered (m_valid && m_ready); wraps

## Operation
- Packing order: sample k of a block (k = 0 first accepted) occupies m_data[BLOCK_W-1-k*SAMPLE_W -: SAMPLE_W]. Sample 0 therefore sits in bits [127:112], and sample 7 in [15:0].
- Sample accept: s_valid && s_ready. Flush accept: s_flush && s_ready.
- Slot index idx counts 0..SAMPLES-1 and increments per accepted sample.
- State FILL:
  - s_ready = 1.
  - A block completes when either:
    - the sample at idx = SAMPLES-1 is accepted, or
    - a flush is accepted with at least one sample in the block, counting a sample accepted in the same cycle.
  - On completion:
    - if the output register is free (m_valid = 0, or m_valid && m_ready this cycle), the block moves to the output register; idx returns to 0; the state stays FILL.
    - otherwise the state becomes STALL; the assembly register holds the block and its fill count.
- State STALL:
  - s_ready = 0; s_valid and s_flush are ignored.
  - On the cycle m_valid && m_ready, the held block moves to the output register. The state returns to FILL with idx = 0.
- Simultaneous s_valid and s_flush: the sample is written first, then the remaining slots are zero-padded. m_fill = idx+1.
- A flush with idx = 0 and no s_valid is a no-op; no empty block is ever emitted.
- Unfilled slots in a flushed block are exactly zero. The assembly register is cleared at the start of each block, so stale data never leaks.
- blk_cnt increments on every m_valid && m_ready and wraps from 2^CNT_W-1 to 0.
- m_data and m_fill stay stable while m_valid = 1 and m_ready = 0.

## Timing
- Reset values:
  - m_valid = 0, m_data = 0, m_fill = 0, blk_cnt = 0.
  - Internal: idx = 0, state = FILL.
  - s_ready is forced 0 while rst is high. It is 1 from the first clock edge after deassertion.
- Latency: a block completing at edge N with a free output register gives m_valid = 1 with the new data after edge N. Minimum latency is 1 cycle from the last accepted sample.
- Throughput: one sample per cycle sustained while m_ready = 1, giving one block per SAMPLES cycles with no bubbles.
- Back-to-back handoff: when m_valid && m_ready and a new block completes in the same cycle, m_valid stays 1 and m_data updates on that edge.
- STALL exit: s_ready returns to 1 the cycle after the handshake that frees the output register.
- Reset mid-block or mid-STALL: the partial or held block is discarded and nothing is emitted. An unconsumed output block is dropped, and blk_cnt is not incremented for it.
- No combinational path from m_ready to s_ready. s_ready depends only on the state register.

## Test plan
- Reset then 8 samples 16'h0001..16'h0008 in 8 consecutive cycles, m_ready = 1:
  - one cycle after the 8th, m_valid = 1, m_data = 128'h0001000200030004000500060007_0008, m_fill = 8.
  - m_valid falls the next cycle; blk_cnt = 1.
- Continuous 24 samples with m_ready = 1: three blocks on exactly cycles 8, 16 and 24 after the first accept, with no s_ready drop; blk_cnt = 3.
- m_ready = 0 while 16 samples are offered:
  - first block held stable; second block completes and the state enters STALL; s_ready = 0 from the cycle after the 16th accept.
  - raise m_ready for one cycle: block 2 appears the next cycle and s_ready = 1 again.
- 3 samples 16'hAAAA, 16'hBBBB, 16'hCCCC, then s_flush: m_data = 128'hAAAABBBBCCCC followed by 80 zero bits, m_fill = 3. A further s_flush with idx = 0 produces no block.
- s_valid with 16'h1234 and s_flush together at idx = 5: m_fill = 6; slot 5 = 16'h1234; slots 6 and 7 = 0.
- Assert rst after 4 accepted samples, and separately during STALL:
  - all outputs return to reset values asynchronously.
  - a subsequent 8-sample block packs from slot 0 with no residue.
